// File: rtl/dcache_miss_ctrl.sv
// rtl/dcache_miss_ctrl.sv - direct-mapped write-back data cache with miss FSM
// Hits complete in the request cycle; misses run victim write-back then line refill.
module dcache_miss_ctrl #(
  parameter int LINE_ADDR_LEN = 3,
  parameter int SET_ADDR_LEN  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RdReq,
  input  logic        WrReq,
  input  logic [31:0] Addr,
  input  logic [31:0] WrData,
  input  logic [3:0]  WrBe,
  output logic [31:0] RdData,
  output logic        Miss,
  output logic        MemRdReq,
  output logic        MemWrReq,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  input  logic        MemWReady,
  input  logic [31:0] MemRData,
  input  logic        MemRValid,
  output logic [31:0] AccessCnt,
  output logic [31:0] MissCnt
);

  localparam int TAG_ADDR_LEN = 30 - LINE_ADDR_LEN - SET_ADDR_LEN;
  localparam int LINE_WORDS   = 1 << LINE_ADDR_LEN;
  localparam int SETS         = 1 << SET_ADDR_LEN;
  localparam int LSB_SET      = 2 + LINE_ADDR_LEN;
  localparam int LSB_TAG      = LSB_SET + SET_ADDR_LEN;
  localparam logic [LINE_ADDR_LEN-1:0] LAST_WORD = '1;

  typedef enum logic [1:0] {S_IDLE, S_WB, S_REFILL} state_e;

  state_e                    state_q, state_d;
  logic [31:0]               data_q [SETS][LINE_WORDS];
  logic [TAG_ADDR_LEN-1:0]   tag_arr_q [SETS];
  logic [SETS-1:0]           valid_q, valid_d, dirty_q, dirty_d;
  logic [SET_ADDR_LEN-1:0]   set_q, set_d;
  logic [TAG_ADDR_LEN-1:0]   tag_q, tag_d, vtag_q, vtag_d;
  logic [LINE_ADDR_LEN-1:0]  wb_cnt_q, wb_cnt_d, rf_cnt_q, rf_cnt_d;
  logic [31:0]               access_cnt_q, access_cnt_d, miss_cnt_q, miss_cnt_d;

  logic [LINE_ADDR_LEN-1:0]  req_word;
  logic [SET_ADDR_LEN-1:0]   req_set;
  logic [TAG_ADDR_LEN-1:0]   req_tag;
  logic                      req, hit, store_hit, rf_fire;
  logic                      unused_byte_offset;

  assign req_word = Addr[LSB_SET-1:2];
  assign req_set  = Addr[LSB_TAG-1:LSB_SET];
  assign req_tag  = Addr[31:LSB_TAG];
  assign unused_byte_offset = ^Addr[1:0];

  assign req       = RdReq | WrReq;
  assign hit       = req & valid_q[req_set] & (tag_arr_q[req_set] == req_tag);
  assign store_hit = (state_q == S_IDLE) & hit & WrReq;
  assign rf_fire   = (state_q == S_REFILL) & MemRValid;

  assign Miss      = (state_q != S_IDLE) | (req & ~hit);
  assign MemWrReq  = (state_q == S_WB);
  assign MemRdReq  = (state_q == S_REFILL);
  assign RdData    = data_q[req_set][req_word];
  assign MemWData  = data_q[set_q][wb_cnt_q];
  assign AccessCnt = access_cnt_q;
  assign MissCnt   = miss_cnt_q;

  always_comb begin
    MemAddr = '0;
    case (state_q)
      S_WB:     MemAddr = {vtag_q, set_q, {(LINE_ADDR_LEN + 2){1'b0}}};
      S_REFILL: MemAddr = {tag_q, set_q, {(LINE_ADDR_LEN + 2){1'b0}}};
      default:  MemAddr = '0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    set_d        = set_q;
    tag_d        = tag_q;
    vtag_d       = vtag_q;
    wb_cnt_d     = wb_cnt_q;
    rf_cnt_d     = rf_cnt_q;
    access_cnt_d = access_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (hit) begin
          access_cnt_d = access_cnt_q + 32'd1;
          if (WrReq) dirty_d[req_set] = 1'b1;
        end else if (req) begin
          set_d      = req_set;
          tag_d      = req_tag;
          vtag_d     = tag_arr_q[req_set];
          miss_cnt_d = miss_cnt_q + 32'd1;
          state_d    = (valid_q[req_set] & dirty_q[req_set]) ? S_WB : S_REFILL;
        end
      end
      S_WB: begin
        if (MemWReady) begin
          wb_cnt_d = wb_cnt_q + 1'b1;
          if (wb_cnt_q == LAST_WORD) begin
            dirty_d[set_q] = 1'b0;
            state_d        = S_REFILL;
          end
        end
      end
      S_REFILL: begin
        if (MemRValid) begin
          rf_cnt_d = rf_cnt_q + 1'b1;
          if (rf_cnt_q == LAST_WORD) begin
            valid_d[set_q] = 1'b1;
            dirty_d[set_q] = 1'b0;
            state_d        = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      valid_q      <= '0;
      dirty_q      <= '0;
      set_q        <= '0;
      tag_q        <= '0;
      vtag_q       <= '0;
      wb_cnt_q     <= '0;
      rf_cnt_q     <= '0;
      access_cnt_q <= '0;
      miss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      dirty_q      <= dirty_d;
      set_q        <= set_d;
      tag_q        <= tag_d;
      vtag_q       <= vtag_d;
      wb_cnt_q     <= wb_cnt_d;
      rf_cnt_q     <= rf_cnt_d;
      access_cnt_q <= access_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  // Line and tag storage carry no reset; valid bits alone qualify their contents.
  always_ff @(posedge clk) begin
    if (store_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (WrBe[b]) data_q[req_set][req_word][8*b +: 8] <= WrData[8*b +: 8];
      end
    end
    if (rf_fire) data_q[set_q][rf_cnt_q] <= MemRData;
    if (rf_fire && (rf_cnt_q == LAST_WORD)) tag_arr_q[set_q] <= tag_q;
  end

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// tb/tb_dcache_miss_ctrl.sv - randomized bench for dcache_miss_ctrl against a flat-memory model
// The model tracks the architectural memory image plus a per-set tag directory.
module tb_dcache_miss_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        RdReq, WrReq;
  logic [31:0] Addr, WrData;
  logic [3:0]  WrBe;
  logic [31:0] RdData;
  logic        Miss, MemRdReq, MemWrReq;
  logic [31:0] MemAddr, MemWData;
  logic        MemWReady;
  logic [31:0] MemRData;
  logic        MemRValid;
  logic [31:0] AccessCnt, MissCnt;

  int errors = 0;
  int checks = 0;

  dcache_miss_ctrl dut (
    .clk(clk), .rst(rst), .RdReq(RdReq), .WrReq(WrReq), .Addr(Addr),
    .WrData(WrData), .WrBe(WrBe), .RdData(RdData), .Miss(Miss),
    .MemRdReq(MemRdReq), .MemWrReq(MemWrReq), .MemAddr(MemAddr),
    .MemWData(MemWData), .MemWReady(MemWReady), .MemRData(MemRData),
    .MemRValid(MemRValid), .AccessCnt(AccessCnt), .MissCnt(MissCnt)
  );

  always #5 clk = ~clk;

  // bmem: what main memory holds; gold: what the CPU should observe (cache-coherent view)
  logic [31:0] bmem [int];
  logic [31:0] gold [int];
  logic [22:0] m_tag [16];
  bit          m_valid [16];
  bit          m_dirty [16];
  int          acc_cnt = 0;
  int          miss_cnt = 0;

  int          t5_rf, t5_cyc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] bm_get(input logic [31:0] a);
    if (bmem.exists(int'(a))) return bmem[int'(a)];
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] gold_get(input logic [31:0] a);
    if (gold.exists(int'(a))) return gold[int'(a)];
    return bm_get(a);
  endfunction

  function automatic bit hs(input int mode, input int cyc);
    if (mode == 0) return 1'b1;
    if (mode == 1) return cyc[0];
    return ($urandom_range(0, 2) != 0);
  endfunction

  task automatic model_reset();
    logic [31:0] la;
    for (int s = 0; s < 16; s++) begin
      if (m_valid[s] && m_dirty[s]) begin
        for (int w = 0; w < 8; w++) begin
          la = {m_tag[s], 4'(s), 5'b0} + 32'(w * 4);
          if (gold.exists(int'(la))) gold.delete(int'(la));
        end
      end
      m_valid[s] = 1'b0;
      m_dirty[s] = 1'b0;
    end
    acc_cnt  = 0;
    miss_cnt = 0;
  endtask

  task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, input int mode, input bit drop);
    int          s, wb_i, rf_i, cyc;
    logic [22:0] t;
    bit          exp_miss, vic_dirty, go, held;
    logic [31:0] vic_base, line_base, wa, m;
    s         = int'(a[8:5]);
    t         = a[31:9];
    wa        = {a[31:2], 2'b00};
    line_base = {a[31:5], 5'b0};
    exp_miss  = (rd || wr) && !(m_valid[s] && m_tag[s] == t);
    held      = rd || wr;
    @(negedge clk);
    RdReq = rd; WrReq = wr; Addr = a; WrData = d; WrBe = be;
    #1;
    check_eq("miss_on_request", 32'(Miss), 32'(exp_miss));
    if (exp_miss) begin
      check_eq("no_mem_req_first_cycle", 32'({MemWrReq, MemRdReq}), 32'd0);
      vic_dirty = m_valid[s] && m_dirty[s];
      vic_base  = {m_tag[s], a[8:5], 5'b0};
      miss_cnt++;
      wb_i = 0; rf_i = 0; cyc = 0;
      while (Miss && cyc < 400) begin
        MemWReady = 1'b0; MemRValid = 1'b0; MemRData = $urandom;
        if (MemWrReq) begin
          go = hs(mode, cyc);
          if (go) begin
            check_eq("wb_addr", MemAddr, vic_base);
            check_eq("wb_data", MemWData, gold_get(vic_base + 32'(wb_i * 4)));
            bmem[int'(vic_base + 32'(wb_i * 4))] = MemWData;
            wb_i++;
          end
          MemWReady = go;
          if (mode == 2) MemRValid = 1'($urandom_range(0, 1));
        end else if (MemRdReq) begin
          go = hs(mode, cyc);
          if (go) begin
            check_eq("rf_addr", MemAddr, line_base);
            MemRData = bm_get(line_base + 32'(rf_i * 4));
            rf_i++;
          end
          MemRValid = go;
          if (mode == 2) MemWReady = 1'($urandom_range(0, 1));
          if (drop && rf_i >= 4) begin
            RdReq = 1'b0; WrReq = 1'b0; held = 1'b0;
          end
        end
        @(negedge clk);
        #1;
        cyc++;
      end
      MemWReady = 1'b0; MemRValid = 1'b0;
      check_eq("miss_within_budget", 32'(cyc < 400), 32'd1);
      check_eq("wb_words", 32'(wb_i), vic_dirty ? 32'd8 : 32'd0);
      check_eq("rf_words", 32'(rf_i), 32'd8);
      if (mode == 0 && !drop) check_eq("miss_cycles", 32'(cyc), vic_dirty ? 32'd17 : 32'd9);
      m_tag[s] = t; m_valid[s] = 1'b1; m_dirty[s] = 1'b0;
    end
    if (held && !Miss) begin
      if (!wr) begin
        check_eq("rd_data", RdData, gold_get(wa));
      end else begin
        m = gold_get(wa);
        for (int b = 0; b < 4; b++) if (be[b]) m[8*b +: 8] = d[8*b +: 8];
        gold[int'(wa)] = m;
        m_dirty[s] = 1'b1;
      end
      acc_cnt++;
    end
    @(posedge clk);
    #1;
    check_eq("access_cnt", AccessCnt, 32'(acc_cnt));
    check_eq("miss_cnt", MissCnt, 32'(miss_cnt));
    RdReq = 1'b0; WrReq = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    int op;
    rst = 1'b1; RdReq = 1'b0; WrReq = 1'b0; Addr = '0; WrData = '0; WrBe = '0;
    MemWReady = 1'b0; MemRData = '0; MemRValid = 1'b0;
    for (int i = 0; i < 16; i++) m_tag[i] = '0;
    for (int i = 0; i < 8; i++) bmem[int'(32'h100 + 32'(i * 4))] = 32'hA0 + 32'(i);
    repeat (3) @(negedge clk);
    #1;
    check_eq("reset_miss", 32'(Miss), 32'd0);
    check_eq("reset_memreq", 32'({MemWrReq, MemRdReq}), 32'd0);
    check_eq("reset_memaddr", MemAddr, 32'd0);
    check_eq("reset_access_cnt", AccessCnt, 32'd0);
    check_eq("reset_miss_cnt", MissCnt, 32'd0);
    rst = 1'b0;

    // cold load, partial store, dirty eviction with every-other-cycle handshakes
    access(1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'h0, 0, 1'b0);
    access(1'b0, 1'b1, 32'h0000_0104, 32'hDEAD_BEEF, 4'b0011, 0, 1'b0);
    access(1'b1, 1'b0, 32'h0000_0104, 32'h0, 4'h0, 0, 1'b0);
    check_eq("t2_merged_word", gold_get(32'h104), 32'h0000_BEEF);
    access(1'b1, 1'b0, 32'h0000_0500, 32'h0, 4'h0, 1, 1'b0);
    check_eq("t3_wb_word1", bm_get(32'h104), 32'h0000_BEEF);

    // reset while the refill is waiting on word 3
    @(negedge clk);
    RdReq = 1'b1; WrReq = 1'b0; Addr = 32'h0000_2040;
    #1;
    check_eq("t5_miss", 32'(Miss), 32'd1);
    t5_rf = 0; t5_cyc = 0;
    while (t5_rf < 3 && t5_cyc < 50) begin
      @(negedge clk);
      #1;
      t5_cyc++;
      MemRValid = MemRdReq;
      MemRData  = bm_get(32'h2040 + 32'(t5_rf * 4));
      if (MemRdReq) t5_rf++;
    end
    @(negedge clk);
    MemRValid = 1'b0;
    #1;
    check_eq("t5_in_refill", 32'(MemRdReq), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("t5_rst_memrdreq", 32'(MemRdReq), 32'd0);
    check_eq("t5_rst_memwrreq", 32'(MemWrReq), 32'd0);
    check_eq("t5_rst_access_cnt", AccessCnt, 32'd0);
    check_eq("t5_rst_miss_cnt", MissCnt, 32'd0);
    RdReq = 1'b0;
    #1;
    check_eq("t5_rst_miss_idle", 32'(Miss), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    access(1'b1, 1'b0, 32'h0000_2040, 32'h0, 4'h0, 0, 1'b0);

    // both requests on a hit act as a store; evict to confirm it went dirty
    access(1'b1, 1'b1, 32'h0000_2048, 32'h1111_2222, 4'hF, 0, 1'b0);
    access(1'b1, 1'b0, 32'h0000_2048, 32'h0, 4'h0, 0, 1'b0);
    access(1'b1, 1'b0, 32'h0000_2240, 32'h0, 4'h0, 2, 1'b0);
    access(1'b1, 1'b0, 32'h0000_2048, 32'h0, 4'h0, 2, 1'b0);

    // request dropped mid-refill: line installed, no access counted
    access(1'b1, 1'b0, 32'h0000_3000, 32'h0, 4'h0, 0, 1'b1);
    access(1'b1, 1'b0, 32'h0000_3004, 32'h0, 4'h0, 0, 1'b0);

    for (int i = 0; i < 250; i++) begin
      a = '0;
      a[10:9] = 2'($urandom_range(0, 3));
      a[6:5]  = 2'($urandom_range(0, 3));
      a[4:2]  = 3'($urandom_range(0, 7));
      a[1:0]  = 2'($urandom_range(0, 3));
      op = $urandom_range(0, 10);
      access((op <= 4) || (op == 9), (op >= 5) && (op <= 9), a, $urandom, 4'($urandom_range(0, 15)),
             $urandom_range(0, 2), $urandom_range(0, 15) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
